wb_slave_mux: RTL
=================

Name: wb_slave_mux

Overview:
- Single-master Wishbone classic interconnect for the user project area.
- Decodes the upstream Wishbone slave port (from Caravel) onto two downstream Wishbone slaves: slot 0 is the fibonacci control block, slot 1 is the SHA1 core.
- Registers each transaction, muxes ack and read data back, and terminates hung or unmapped accesses with an error response so the bus never stalls.
- Replaces the direct wiring of both slaves onto wbs_ack_o and wbs_dat_o.

Parameters:
- S0_BASE, 32'h3000_0000, base address of slave 0
- S1_BASE, 32'h3000_1000, base address of slave 1
- ADDR_MASK, 32'hFFFF_F000, bits compared for decode
- TIMEOUT, 16, maximum downstream wait in cycles (>=2)
- ERR_DATA, 32'hDEAD_BEEF, read data returned on error

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  synchronous active-high reset
- wbs_stb_i  in  1  upstream strobe
- wbs_cyc_i  in  1  upstream cycle
- wbs_we_i  in  1  upstream write enable
- wbs_sel_i  in  4  upstream byte select
- wbs_dat_i  in  32  upstream write data
- wbs_adr_i  in  32  upstream address
- wbs_ack_o  out  1  upstream ack
- wbs_dat_o  out  32  upstream read data
- s_cyc_o  out  2  per-slave cycle, one-hot
- s_stb_o  out  2  per-slave strobe, one-hot
- s_we_o  out  1  shared write enable
- s_sel_o  out  4  shared byte select
- s_adr_o  out  32  shared address
- s_dat_o  out  32  shared write data
- s0_ack_i  in  1  slave 0 ack
- s0_dat_i  in  32  slave 0 read data
- s1_ack_i  in  1  slave 1 ack
- s1_dat_i  in  32  slave 1 read data
- err_o  out  1  one-cycle pulse on error termination
- err_count_o  out  8  saturating error count

Behaviour:
- Reset (wb_rst_i high at a clock edge): state IDLE. All of the following go to 0: wbs_ack_o, wbs_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, err_o, err_count_o, timeout counter. Reset mid-transaction aborts it with no ack.
- FSM states:
  - IDLE:
    - Waits for wbs_cyc_i & wbs_stb_i while wbs_ack_o is 0.
    - On request, latches adr/dat/we/sel and decodes.
    - Decode: (adr & ADDR_MASK) == (S0_BASE & ADDR_MASK) selects slot 0; otherwise a match on S1_BASE selects slot 1. Slot 0 wins if both match.
    - Mapped address: next state BUSY, with s_cyc_o/s_stb_o bit for the slot set from the next cycle.
    - Unmapped address: next state RESP with error.
  - BUSY:
    - Downstream strobe held and latched fields stable.
    - Only the selected slave's ack is observed; the other slave's ack is ignored.
    - Selected ack high: capture its data (write: capture value irrelevant, return 0), drop s_cyc_o/s_stb_o next cycle, go to RESP.
    - No ack: increment the counter. When the counter reaches TIMEOUT-1 without ack, drop the strobe, go to RESP with error.
    - Ack arriving in the expiry cycle wins; no error.
    - wbs_cyc_i low (master abort): drop the strobe, go to IDLE, no ack, no error.
  - RESP:
    - wbs_ack_o = 1 for exactly one cycle.
    - wbs_dat_o = captured data, or ERR_DATA on error reads; 0 on writes.
    - On error, err_o = 1 for the same cycle and err_count_o increments, saturating at 255.
    - Next state IDLE.
- wbs_dat_o holds its value until the next RESP.
- Latency (request seen at edge T):
  - Downstream strobe visible from T+1.
  - With slave ack at edge T+k, upstream ack at T+k+1.
  - Unmapped access: ack at T+1.
  - Timeout: ack at T+TIMEOUT+1.
- The block never asserts downstream strobe and upstream ack in the same cycle.
- A request held high through RESP (back-to-back) is accepted in the following IDLE cycle. IDLE ignores stb while wbs_ack_o is 1, so there is no double-accept.

Test Plan:
- Read slot 0: adr 32'h3000_0004, s0 acks 2 cycles after its strobe with 32'h0000_0055 -> s_stb_o=2'b01, wbs_ack_o one cycle with wbs_dat_o=32'h55, err_count_o=0.
- Write slot 1: adr 32'h3000_1008, dat 32'hCAFE_F00D, sel 4'hF -> s_stb_o=2'b10, s_dat_o=32'hCAFE_F00D, s_we_o=1; ack forwarded one cycle after s1_ack_i.
- Unmapped read: adr 32'h3000_2000 -> no downstream strobe, ack at T+1 with 32'hDEAD_BEEF, err_o pulse, err_count_o=1.
- Timeout: slot 0 never acks; s1_ack_i pulses meanwhile -> strobe held 16 cycles, s1 ack ignored, ack at T+17 with ERR_DATA, err_count_o increments.
- Boundaries:
  - Ack on the 16th BUSY cycle -> normal data, no error.
  - wbs_cyc_i dropped in BUSY -> strobe drops next cycle, no ack.
  - wb_rst_i asserted in BUSY -> all outputs 0 next cycle.
- Saturation: 260 unmapped accesses -> err_count_o stops at 255.

Source files
------------

// File: rtl/wb_slave_mux.sv
// wb_slave_mux: single-master Wishbone classic interconnect.
// Decodes the upstream slave port onto two downstream slaves (slot 0 and
// slot 1). It registers each transaction and muxes ack and read data back.
// Hung or unmapped accesses end with an error response, so the bus never
// stalls.
//
// Ports:
//   wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//   wbs_*_i / wbs_*_o       upstream Wishbone slave port
//   s_cyc_o, s_stb_o        per-slave one-hot cycle/strobe
//   s_we_o, s_sel_o,
//   s_adr_o, s_dat_o        shared latched downstream request fields
//   s0_ack_i, s0_dat_i      slave 0 response
//   s1_ack_i, s1_dat_i      slave 1 response
//   err_o                   one-cycle pulse alongside an error ack
//   err_count_o             saturating count of error terminations
module wb_slave_mux #(
    parameter logic [31:0] S0_BASE   = 32'h3000_0000,
    parameter logic [31:0] S1_BASE   = 32'h3000_1000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_F000,
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [1:0]  s_cyc_o,
    output logic [1:0]  s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic        s0_ack_i,
    input  logic [31:0] s0_dat_i,
    input  logic        s1_ack_i,
    input  logic [31:0] s1_dat_i,
    output logic        err_o,
    output logic [7:0]  err_count_o
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state, state_next;
    logic        slot;
    logic [15:0] cnt;

    logic        req, hit0, hit1;
    logic        sel_ack;
    logic [31:0] sel_dat, err_dat;
    logic        go_busy, go_ok, go_err, abort, cnt_inc;

    assign req     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign hit0    = (wbs_adr_i & ADDR_MASK) == (S0_BASE & ADDR_MASK);
    assign hit1    = (wbs_adr_i & ADDR_MASK) == (S1_BASE & ADDR_MASK);
    assign sel_ack = slot ? s1_ack_i : s0_ack_i;
    assign sel_dat = slot ? s1_dat_i : s0_dat_i;
    // Unmapped errors come straight from IDLE, before the request is latched.
    assign err_dat = ((state == IDLE) ? wbs_we_i : s_we_o) ? '0 : ERR_DATA;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        go_busy    = 1'b0;
        go_ok      = 1'b0;
        go_err     = 1'b0;
        abort      = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (hit0 | hit1) begin
                        go_busy    = 1'b1;
                        state_next = BUSY;
                    end else begin
                        go_err     = 1'b1;
                        state_next = RESP;
                    end
                end
            end
            BUSY: begin
                // A master abort takes priority over any slave response.
                if (!wbs_cyc_i) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (sel_ack) begin
                    go_ok      = 1'b1;
                    state_next = RESP;
                end else if (cnt == 16'(TIMEOUT - 1)) begin
                    go_err     = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= '0;
            s_cyc_o     <= '0;
            s_stb_o     <= '0;
            s_we_o      <= 1'b0;
            s_sel_o     <= '0;
            s_adr_o     <= '0;
            s_dat_o     <= '0;
            err_o       <= 1'b0;
            err_count_o <= '0;
            cnt         <= '0;
            slot        <= 1'b0;
        end else begin
            // The ack register is set on entry to RESP and cleared on leaving it.
            wbs_ack_o <= go_ok | go_err;
            err_o     <= go_err;

            if (state == IDLE && req) begin
                s_adr_o <= wbs_adr_i;
                s_dat_o <= wbs_dat_i;
                s_we_o  <= wbs_we_i;
                s_sel_o <= wbs_sel_i;
            end

            if (go_busy) begin
                s_cyc_o <= hit0 ? 2'b01 : 2'b10;
                s_stb_o <= hit0 ? 2'b01 : 2'b10;
                slot    <= ~hit0;
                cnt     <= '0;
            end else if (go_ok | go_err | abort) begin
                s_cyc_o <= '0;
                s_stb_o <= '0;
            end

            if (cnt_inc) begin
                cnt <= cnt + 16'd1;
            end

            if (go_ok) begin
                wbs_dat_o <= s_we_o ? '0 : sel_dat;
            end else if (go_err) begin
                wbs_dat_o <= err_dat;
            end

            if (go_err && err_count_o != 8'hFF) begin
                err_count_o <= err_count_o + 8'd1;
            end
        end
    end

endmodule
